// File: rtl/button_cond_pkg.sv
// Shared types and width helpers for the button conditioner.
package button_pkg;

    // Per-channel press tracking states.
    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        HELD_LONG
    } btn_state_e;

    // Debounce counter must hold values 0..cycles.
    function automatic int deb_cnt_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    // Hold counter only ever reaches cycles-2, so $clog2(cycles) bits suffice.
    function automatic int hold_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_cond_ch.sv
// One button channel: synchroniser, polarity fix, debounce and press FSM.
// `release` is a reserved word in SystemVerilog, hence the release_pulse name.
module button_cond_ch
    import button_pkg::*;
#(
    parameter int   SYNC_STAGES     = 3,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter int   LONG_CYCLES     = 1000,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int CNT_W  = deb_cnt_w(DEBOUNCE_CYCLES);
    localparam int HOLD_W = hold_cnt_w(LONG_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync_p;
    logic [SYNC_STAGES-1:0] vld_p;
    logic [CNT_W-1:0]       cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    btn_state_e             state;

    logic s;
    logic flip;
    logic rise_evt;
    logic fall_evt;

    // The valid chain keeps the debouncer idle until the synchroniser holds real
    // pin samples rather than reset zeros, so every channel starts counting at
    // the same point regardless of polarity.
    assign s        = sync_p[SYNC_STAGES-1] ^ INVERT;
    assign flip     = vld_p[SYNC_STAGES-1] && (s != level) && (cnt == CNT_LAST);
    assign rise_evt = flip && s;
    assign fall_evt = flip && !s;

    // Synchroniser stages with a matching fill-valid shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
            vld_p  <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], in};
            vld_p  <= {vld_p[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Stability counter: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level         <= 1'b0;
            cnt           <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= rise_evt;
            release_pulse <= fall_evt;
            if (!vld_p[SYNC_STAGES-1] || (s == level)) begin
                cnt <= '0;
            end else if (flip) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Press tracking FSM; a release on the threshold cycle suppresses long_press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RELEASED;
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            case (state)
                RELEASED: begin
                    if (level && !fall_evt) begin
                        state    <= PRESSED;
                        hold_cnt <= '0;
                    end
                end
                PRESSED: begin
                    if (fall_evt) begin
                        state    <= RELEASED;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        long_press <= 1'b1;
                        state      <= HELD_LONG;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                HELD_LONG: begin
                    if (fall_evt) begin
                        state    <= RELEASED;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= RELEASED;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_cond.sv
// Multi-channel button conditioner: independent per-channel instances.
module button_cond
    import button_pkg::*;
#(
    parameter int                CHANNELS        = 4,
    parameter int                SYNC_STAGES     = 3,
    parameter int                DEBOUNCE_CYCLES = 16,
    parameter int                LONG_CYCLES     = 1000,
    parameter logic [CHANNELS-1:0] INVERT        = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_cond_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .INVERT          (INVERT[i])
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .in            (in[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i])
        );
    end

endmodule
